// File: rtl/seq_det_prog_if.sv
// Bus bundle for the programmable serial sequence detector: bit stream,
// configuration load port and detection outputs.
interface seq_det_prog_if #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 8
);
  localparam int LEN_W = $clog2(MAX_LEN) + 1;

  logic               valid_i;
  logic               x_i;
  logic               cfg_load_i;
  logic [MAX_LEN-1:0] cfg_pattern_i;
  logic [LEN_W-1:0]   cfg_len_i;
  logic               cfg_overlap_i;
  logic               det_o;
  logic [CNT_W-1:0]   det_cnt_o;
  logic               cfg_err_o;

  modport master (
    output valid_i, x_i, cfg_load_i, cfg_pattern_i, cfg_len_i, cfg_overlap_i,
    input  det_o, det_cnt_o, cfg_err_o
  );

  modport slave (
    input  valid_i, x_i, cfg_load_i, cfg_pattern_i, cfg_len_i, cfg_overlap_i,
    output det_o, det_cnt_o, cfg_err_o
  );
endinterface

// File: rtl/seq_det_prog.sv
// Programmable serial pattern detector: runtime pattern/length/overlap,
// registered one-cycle detect pulse and saturating detection counter.
module seq_det_prog #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 8
) (
  input logic          clk,
  input logic          reset,
  seq_det_prog_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_LEN) + 1;
  localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   DEF_LEN   = LEN_W'(12);
  localparam logic [MAX_LEN-1:0] DEF_PAT   = MAX_LEN'(12'hEDB);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  typedef enum logic {FILL = 1'b0, ARMED = 1'b1} state_t;

  state_t             state_q, state_next;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [MAX_LEN-1:0] hist_q, hist_next;
  logic [LEN_W-1:0]   fill_q, fill_next;
  logic               det_q, det_next;
  logic               err_q, err_next;
  logic [CNT_W-1:0]   cnt_q, cnt_next;

  logic               consume, len_ok, load_ok, load_bad;
  logic               full_next, match;
  logic [LEN_W-1:0]   fill_inc;
  logic [MAX_LEN-1:0] shifted, mask;

  // Only the low len bits of history take part in the comparison.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
    assign mask[gi] = (LEN_W'(gi) < len_q);
  end

  assign consume   = bus.valid_i & ~bus.cfg_load_i;
  assign len_ok    = (bus.cfg_len_i != '0) && (bus.cfg_len_i <= MAX_LEN_L);
  assign load_ok   = bus.cfg_load_i & len_ok;
  assign load_bad  = bus.cfg_load_i & ~len_ok;
  assign fill_inc  = fill_q + 1'b1;
  assign shifted   = {hist_q[MAX_LEN-2:0], bus.x_i};
  assign full_next = consume && ((state_q == ARMED) || (fill_inc == len_q));
  assign match     = full_next && (((shifted ^ pattern_q) & mask) == '0);

  always_ff @(posedge clk) begin
    if (reset) state_q <= FILL;
    else       state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    if (load_ok) begin
      state_next = FILL;
    end else if (state_q == FILL) begin
      if (full_next && !(match && !overlap_q)) state_next = ARMED;
    end else if (match && !overlap_q) begin
      state_next = FILL;
    end
  end

  always_comb begin
    hist_next = hist_q;
    fill_next = fill_q;
    det_next  = match;
    err_next  = load_bad;
    cnt_next  = (match && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;
    if (load_ok) begin
      hist_next = '0;
      fill_next = '0;
    end else if (consume) begin
      hist_next = shifted;
      if (match && !overlap_q)  fill_next = '0;
      else if (state_q == FILL) fill_next = fill_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q <= DEF_PAT;
      len_q     <= DEF_LEN;
      overlap_q <= 1'b1;
      hist_q    <= '0;
      fill_q    <= '0;
      det_q     <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (load_ok) begin
        pattern_q <= bus.cfg_pattern_i;
        len_q     <= bus.cfg_len_i;
        overlap_q <= bus.cfg_overlap_i;
      end
      hist_q <= hist_next;
      fill_q <= fill_next;
      det_q  <= det_next;
      err_q  <= err_next;
      cnt_q  <= cnt_next;
    end
  end

  assign bus.det_o     = det_q;
  assign bus.cfg_err_o = err_q;
  assign bus.det_cnt_o = cnt_q;
endmodule
